// File: rtl/blackjack.sv
// Single-player blackjack hand controller.
// Requests cards from an external source, accumulates the hand total with soft-ace handling,
// asks the player hit/stand once two cards are held, and declares victory or defeat.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-low reset
//   begin_s      - start a game (sampled in IDLE and in WIN/LOSE)
//   cval         - card value, 2..10 face value, 11 = ace; others invalid
//   ready        - card source presents a valid cval
//   opt          - player choice in DECIDE: 0 = hit, 1 = stand
//   end_s        - game over (WIN or LOSE)
//   request      - card requested (REQ state)
//   hand         - current hand total
//   victory      - WIN state
//   defeat       - LOSE state
//   seg_ace      - active-low 7-seg digit {g,f,e,d,c,b,a} of ace
//   seg_nr_cards - active-low 7-seg hex digit of nr_cards
//   ace          - aces received, saturating at 7
//   nr_cards     - cards received, saturating at 15
//   debug_state  - current state code
module blackjack #(
  parameter int unsigned BLACKJACK = 21,
  parameter int unsigned STAND_MIN = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       begin_s,
  input  logic [3:0] cval,
  input  logic       ready,
  input  logic       opt,
  output logic       end_s,
  output logic       request,
  output logic [4:0] hand,
  output logic       victory,
  output logic       defeat,
  output logic [6:0] seg_ace,
  output logic [6:0] seg_nr_cards,
  output logic [2:0] ace,
  output logic [3:0] nr_cards,
  output logic [3:0] debug_state
);

  typedef enum logic [3:0] {
    StIdle   = 4'b0000,
    StInit   = 4'b0001,
    StDecide = 4'b0010,
    StAdd    = 4'b0011,
    StCheck  = 4'b0100,
    StReq    = 4'b0101,
    StWin    = 4'b0110,
    StLose   = 4'b0111
  } state_e;

  localparam logic [5:0] SumMax   = 6'(BLACKJACK);
  localparam logic [4:0] HandMax  = 5'(BLACKJACK);
  localparam logic [4:0] StandMin = 5'(STAND_MIN);

  state_e     state_q;
  logic [4:0] hand_q;
  logic [2:0] ace_q;
  logic [3:0] nr_cards_q;
  logic [3:0] card_q;
  logic [2:0] soft_q;

  // Result of adding the latched card, including at most one soft-ace reduction.
  logic [5:0] sum_raw;
  logic [5:0] sum_adj;
  logic [2:0] soft_inc;
  logic [2:0] soft_adj;
  logic       card_valid;

  always_comb begin
    sum_raw  = {1'b0, hand_q} + {2'b00, card_q};
    soft_inc = soft_q + ((card_q == 4'd11) ? 3'd1 : 3'd0);
    sum_adj  = sum_raw;
    soft_adj = soft_inc;
    if (sum_raw > SumMax && soft_inc != 3'd0) begin
      sum_adj  = sum_raw - 6'd10;
      soft_adj = soft_inc - 3'd1;
    end
  end

  assign card_valid = ready && (cval >= 4'd2) && (cval <= 4'd11);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      hand_q     <= '0;
      ace_q      <= '0;
      nr_cards_q <= '0;
      card_q     <= '0;
      soft_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (begin_s) state_q <= StInit;
        StInit: begin
          hand_q     <= '0;
          ace_q      <= '0;
          nr_cards_q <= '0;
          soft_q     <= '0;
          state_q    <= StReq;
        end
        StReq: begin
          if (card_valid) begin
            card_q  <= cval;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          if (card_q == 4'd11 && ace_q != 3'd7) ace_q <= ace_q + 3'd1;
          if (nr_cards_q != 4'd15) nr_cards_q <= nr_cards_q + 4'd1;
          soft_q  <= soft_adj;
          // A hand of at most 20 plus an 11 stays below 32, so 5 bits suffice.
          hand_q  <= sum_adj[4:0];
          state_q <= StCheck;
        end
        StCheck: begin
          if (hand_q > HandMax)          state_q <= StLose;
          else if (hand_q == HandMax)    state_q <= StWin;
          else if (nr_cards_q < 4'd2)    state_q <= StReq;
          else                           state_q <= StDecide;
        end
        StDecide: begin
          if (!opt)                      state_q <= StReq;
          else if (hand_q >= StandMin)   state_q <= StWin;
          else                           state_q <= StLose;
        end
        StWin, StLose: if (!begin_s) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign request      = (state_q == StReq);
  assign victory      = (state_q == StWin);
  assign defeat       = (state_q == StLose);
  assign end_s        = victory | defeat;
  assign debug_state  = state_q;
  assign hand         = hand_q;
  assign ace          = ace_q;
  assign nr_cards     = nr_cards_q;
  assign seg_ace      = hex_to_seg({1'b0, ace_q});
  assign seg_nr_cards = hex_to_seg(nr_cards_q);

endmodule

// File: tb/tb_blackjack.sv
module tb_blackjack;

  logic       clk;
  logic       rst;
  logic       begin_s;
  logic [3:0] cval;
  logic       ready;
  logic       opt;
  logic       end_s;
  logic       request;
  logic [4:0] hand;
  logic       victory;
  logic       defeat;
  logic [6:0] seg_ace;
  logic [6:0] seg_nr_cards;
  logic [2:0] ace;
  logic [3:0] nr_cards;
  logic [3:0] debug_state;

  int checks = 0;
  int errors = 0;
  int decide_cnt = 0;

  localparam logic [3:0] S_IDLE = 4'd0, S_DECIDE = 4'd2, S_ADD = 4'd3,
                         S_CHECK = 4'd4, S_REQ = 4'd5, S_WIN = 4'd6, S_LOSE = 4'd7;

  blackjack dut (
    .clk         (clk),
    .rst         (rst),
    .begin_s     (begin_s),
    .cval        (cval),
    .ready       (ready),
    .opt         (opt),
    .end_s       (end_s),
    .request     (request),
    .hand        (hand),
    .victory     (victory),
    .defeat      (defeat),
    .seg_ace     (seg_ace),
    .seg_nr_cards(seg_nr_cards),
    .ace         (ace),
    .nr_cards    (nr_cards),
    .debug_state (debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each DECIDE lasts exactly one cycle, so one negedge sample per visit.
  always @(negedge clk) if (debug_state == S_DECIDE) decide_cnt++;

  task automatic wait_state(input logic [3:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (debug_state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Wait for REQ, present card c, return the hand seen in the following CHECK.
  task automatic deal(input logic [3:0] c, output bit ok, output logic [4:0] h);
    bit ok1, ok2;
    wait_state(S_REQ, ok1);
    cval = c;
    wait_state(S_CHECK, ok2);
    ok = ok1 && ok2;
    h = hand;
  endtask

  task automatic restart();
    bit ok;
    begin_s = 1'b0;
    wait_state(S_IDLE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_idle: state=%0d required=0", debug_state); end
    begin_s = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; begin_s = 1'b0; ready = 1'b0; cval = 4'd0; opt = 1'b0;
    #3;
    checks++;
    if (debug_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got=%0d exp=0", debug_state); end
    checks++;
    if ({hand, ace, nr_cards} !== 12'd0) begin
      errors++; $display("FAIL reset_counters: hand=%0d ace=%0d nr=%0d exp=0", hand, ace, nr_cards);
    end
    checks++;
    if ({request, victory, defeat, end_s} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got=%b exp=0000", {request, victory, defeat, end_s});
    end
    checks++;
    if (seg_ace !== 7'b1000000 || seg_nr_cards !== 7'b1000000) begin
      errors++; $display("FAIL reset_seg: ace=%b nr=%b exp=1000000", seg_ace, seg_nr_cards);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_soft_win();
    bit ok; logic [4:0] h;
    ready = 1'b1; begin_s = 1'b1; opt = 1'b0;
    deal(4'd11, ok, h);
    checks++;
    if (!ok || h !== 5'd11) begin errors++; $display("FAIL soft_card1: hand=%0d exp=11", h); end
    deal(4'd9, ok, h);
    checks++;
    if (!ok || h !== 5'd20) begin errors++; $display("FAIL soft_card2: hand=%0d exp=20", h); end
    wait_state(S_DECIDE, ok); opt = 1'b0;
    deal(4'd3, ok, h);
    checks++;
    if (!ok || h !== 5'd13) begin errors++; $display("FAIL soft_card3: hand=%0d exp=13", h); end
    wait_state(S_DECIDE, ok); opt = 1'b0;
    deal(4'd5, ok, h);
    checks++;
    if (!ok || h !== 5'd18) begin errors++; $display("FAIL soft_card4: hand=%0d exp=18", h); end
    wait_state(S_DECIDE, ok); opt = 1'b1;
    wait_state(S_WIN, ok);
    checks++;
    if (!ok || victory !== 1'b1 || end_s !== 1'b1 || defeat !== 1'b0) begin
      errors++; $display("FAIL soft_win_flags: state=%0d victory=%b end=%b exp state 6", debug_state,
                         victory, end_s);
    end
    checks++;
    if (hand !== 5'd18 || ace !== 3'd1 || nr_cards !== 4'd4) begin
      errors++; $display("FAIL soft_win_totals: hand=%0d ace=%0d nr=%0d exp 18/1/4", hand, ace,
                         nr_cards);
    end
    checks++;
    if (seg_nr_cards !== 7'b0011001 || seg_ace !== 7'b1111001) begin
      errors++; $display("FAIL soft_win_seg: nr=%b ace=%b exp 0011001/1111001", seg_nr_cards,
                         seg_ace);
    end
  endtask

  task automatic test_bust();
    bit ok; logic [4:0] h; int d0;
    restart();
    d0 = decide_cnt;
    deal(4'd10, ok, h);
    deal(4'd6, ok, h);
    checks++;
    if (!ok || h !== 5'd16) begin errors++; $display("FAIL bust_card2: hand=%0d exp=16", h); end
    wait_state(S_DECIDE, ok); opt = 1'b0;
    deal(4'd10, ok, h);
    checks++;
    if (!ok || h !== 5'd26) begin errors++; $display("FAIL bust_card3: hand=%0d exp=26", h); end
    wait_state(S_LOSE, ok);
    checks++;
    if (!ok || defeat !== 1'b1 || end_s !== 1'b1 || victory !== 1'b0) begin
      errors++; $display("FAIL bust_lose: state=%0d defeat=%b end=%b exp state 7", debug_state,
                         defeat, end_s);
    end
    checks++;
    if (decide_cnt - d0 !== 1) begin
      errors++; $display("FAIL bust_decides: got=%0d exp=1", decide_cnt - d0);
    end
  endtask

  task automatic test_natural();
    bit ok; logic [4:0] h; int d0;
    restart();
    d0 = decide_cnt;
    deal(4'd11, ok, h);
    deal(4'd10, ok, h);
    checks++;
    if (!ok || h !== 5'd21) begin errors++; $display("FAIL natural_hand: hand=%0d exp=21", h); end
    wait_state(S_WIN, ok);
    checks++;
    if (!ok || ace !== 3'd1 || nr_cards !== 4'd2) begin
      errors++; $display("FAIL natural_win: state=%0d ace=%0d nr=%0d exp 6/1/2", debug_state, ace,
                         nr_cards);
    end
    checks++;
    if (decide_cnt - d0 !== 0) begin
      errors++; $display("FAIL natural_decides: got=%0d exp=0", decide_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (debug_state !== S_WIN || hand !== 5'd21) begin
        errors++; $display("FAIL win_hold: state=%0d hand=%0d exp 6/21", debug_state, hand);
      end
    end
    begin_s = 1'b0;
    @(negedge clk);
    checks++;
    if (debug_state !== S_IDLE || end_s !== 1'b0) begin
      errors++; $display("FAIL win_release: state=%0d end=%b exp 0/0", debug_state, end_s);
    end
    begin_s = 1'b1;
  endtask

  task automatic test_double_ace();
    bit ok; logic [4:0] h;
    restart();
    deal(4'd11, ok, h);
    deal(4'd11, ok, h);
    checks++;
    if (!ok || h !== 5'd12 || ace !== 3'd2) begin
      errors++; $display("FAIL double_ace: hand=%0d ace=%0d exp 12/2", h, ace);
    end
    checks++;
    if (seg_ace !== 7'b0100100) begin
      errors++; $display("FAIL double_ace_seg: got=%b exp=0100100", seg_ace);
    end
    wait_state(S_DECIDE, ok); opt = 1'b1;
    wait_state(S_LOSE, ok);
    checks++;
    if (!ok || defeat !== 1'b1 || hand !== 5'd12) begin
      errors++; $display("FAIL double_ace_stand: state=%0d hand=%0d exp 7/12", debug_state, hand);
    end
    opt = 1'b0;
  endtask

  task automatic test_req_stall();
    bit ok;
    ready = 1'b0;
    restart();
    wait_state(S_REQ, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (debug_state !== S_REQ || request !== 1'b1) begin
        errors++; $display("FAIL stall_noready: state=%0d request=%b exp 5/1", debug_state, request);
      end
    end
    ready = 1'b1; cval = 4'd0;
    @(negedge clk);
    checks++;
    if (debug_state !== S_REQ || request !== 1'b1) begin
      errors++; $display("FAIL stall_invalid: state=%0d request=%b exp 5/1", debug_state, request);
    end
    cval = 4'd7;
    @(negedge clk);
    checks++;
    if (debug_state !== S_ADD) begin errors++; $display("FAIL stall_add: state=%0d exp=3", debug_state); end
    @(negedge clk);
    checks++;
    if (debug_state !== S_CHECK || hand !== 5'd7 || nr_cards !== 4'd1) begin
      errors++; $display("FAIL stall_hand: state=%0d hand=%0d nr=%0d exp 4/7/1", debug_state, hand,
                         nr_cards);
    end
  endtask

  task automatic test_async_reset();
    bit ok; logic [4:0] h;
    deal(4'd5, ok, h);
    checks++;
    if (!ok || h !== 5'd12) begin errors++; $display("FAIL abort_hand: hand=%0d exp=12", h); end
    wait_state(S_DECIDE, ok);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (!ok || debug_state !== S_IDLE || {hand, ace, nr_cards} !== 12'd0) begin
      errors++; $display("FAIL abort_reset: state=%0d hand=%0d ace=%0d nr=%0d exp all 0",
                         debug_state, hand, ace, nr_cards);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_soft_win();
    test_bust();
    test_natural();
    test_back_to_back();
    test_double_ace();
    test_req_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blackjack.md
Name: blackjack

Overview:
- Single-player blackjack hand controller.
- Requests cards from an external card source and accumulates the hand value, including soft/hard ace handling.
- Asks the player hit/stand after each card once two cards are held, and declares victory or defeat.
- Drives two 7-segment digits (ace count, card count) and exposes its state code for debug.

Parameters:
- BLACKJACK, 21, target total; above this is bust.
- STAND_MIN, 17, minimum total for a stand to win.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- begin_s  input  1  start a game (level, sampled in IDLE and in terminal states).
- cval  input  4  card value: 2..10 face value, 11 = ace; 0, 1, 12..15 invalid.
- ready  input  1  card source has valid cval.
- opt  input  1  player choice in DECIDE: 0 = hit, 1 = stand.
- end_s  output  1  game over (WIN or LOSE).
- request  output  1  card requested (high in REQ).
- hand  output  5  current hand total.
- victory  output  1  high in WIN.
- defeat  output  1  high in LOSE.
- seg_ace  output  7  7-seg digit of ace.
- seg_nr_cards  output  7  7-seg hex digit of nr_cards.
- ace  output  3  number of aces received, saturates at 7.
- nr_cards  output  4  number of cards received, saturates at 15.
- debug_state  output  4  current state code.

Behaviour:
- Reset (async, rst=0): state IDLE; hand, ace, nr_cards and the internal soft-ace count all 0. All flags low. Both segment outputs show "0".
- State codes: IDLE=0000, INIT=0001, DECIDE=0010, ADD=0011, CHECK=0100, REQ=0101, WIN=0110, LOSE=0111. Unused codes go to IDLE.
- Outputs are Moore-decoded from state: request=(REQ), victory=(WIN), defeat=(LOSE), end_s=(WIN|LOSE), debug_state=state.
- IDLE: go to INIT when begin_s=1, else stay.
- INIT (1 cycle): clear hand, ace, nr_cards and soft count; go to REQ.
- REQ: at a clock edge where ready=1 and cval is in 2..11, latch cval and go to ADD. Otherwise (ready=0 or invalid cval) stay in REQ with request held high. With ready=1 and a valid card, REQ lasts exactly one cycle.
- ADD (1 cycle):
  - Compute a 6-bit sum = hand + card.
  - If card=11, increment ace (saturating) and the soft count.
  - If sum > BLACKJACK and soft count > 0, subtract 10 and decrement soft count (at most one reduction per card).
  - hand <= sum[4:0]; the maximum reachable value is 31, so no loss.
  - nr_cards increments, saturating.
  - Go to CHECK.
- CHECK (1 cycle), in priority order:
  - hand > 21 -> LOSE.
  - hand = 21 -> WIN.
  - nr_cards < 2 -> REQ.
  - otherwise -> DECIDE.
- DECIDE (exactly 1 cycle): opt sampled at the clock edge leaving DECIDE.
  - opt=0 -> REQ.
  - opt=1 -> WIN if hand >= STAND_MIN, else LOSE.
- WIN/LOSE: hold hand, ace, nr_cards and flags. Go to IDLE when begin_s=0; stay while begin_s=1.
- begin_s changes in any other state are ignored. An async reset at any time aborts the game immediately.
- 7-seg encoding: active-low, bit order {g,f,e,d,c,b,a}, hex glyphs 0-F (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110). Combinational from ace (zero-extended) and nr_cards.

Test Plan:
- Reset, then begin_s=1, ready=1. Cards 11, 9, 3, 5 with opt=0 at the first two DECIDEs and opt=1 at the third -> hand sequence 11, 20, 13, 18; ends in WIN. Final values: victory=1, end_s=1, hand=18, ace=1, nr_cards=4, seg_nr_cards=0011001.
- Cards 10, 6, opt=0, card 10 -> hand 26, LOSE: defeat=1, end_s=1, no DECIDE after the bust.
- Cards 11, 10 -> hand 21 after two cards, WIN with no DECIDE visited.
- Cards 11, 11 -> first ace reduced, hand 12, ace=2. Then opt=1 -> LOSE (12 < 17).
- In REQ with ready=0 for 3 cycles, then cval=0 with ready=1 -> remain in REQ with request=1. Then cval=7 -> ADD, hand=7.
- Assert rst=0 mid-game in DECIDE -> immediately IDLE with all counters 0. Separately, begin_s held high in WIN keeps WIN; begin_s=0 -> IDLE.
